// File: rtl/mul_wb_seq_if.sv
// Register-file bus between the multiply stage and the 8x32 dual-write file.
// Master drives read/write addresses and write data; slave returns QA/QB.
interface mul_wb_seq_if #(
  parameter int W  = 32,
  parameter int AW = 3
);
  logic [W-1:0]  QA;
  logic [W-1:0]  QB;
  logic [AW-1:0] Addr_A;
  logic [AW-1:0] Addr_B;
  logic          WE;
  logic [AW-1:0] Addr_W1;
  logic [AW-1:0] Addr_W2;
  logic [W-1:0]  Di1;
  logic [W-1:0]  Di2;

  modport master (
    input  QA, QB,
    output Addr_A, Addr_B,
    output WE, Addr_W1, Addr_W2, Di1, Di2
  );

  modport slave (
    output QA, QB,
    input  Addr_A, Addr_B,
    input  WE, Addr_W1, Addr_W2, Di1, Di2
  );
endinterface

// File: rtl/mul_wb_seq.sv
// Sequential 32x32 shift-add multiplier that reads and writes back
// its operands/product through the dual-write register file.
module mul_wb_seq #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          cr,
  input  logic          start,
  input  logic          signed_op,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst_lo,
  input  logic [AW-1:0] dst_hi,
  mul_wb_seq_if.master  rf,
  output logic          busy,
  output logic          done,
  output logic          dst_err
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    MUL,
    WB
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]  addr_a_q, addr_a_d;
  logic [AW-1:0]  addr_b_q, addr_b_d;
  logic [AW-1:0]  dlo_q, dlo_d;
  logic [AW-1:0]  dhi_q, dhi_d;
  logic           sgn_q, sgn_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [AW-1:0]  aw1_q, aw1_d;
  logic [AW-1:0]  aw2_q, aw2_d;
  logic [W-1:0]   di1_q, di1_d;
  logic [W-1:0]   di2_q, di2_d;

  logic [W:0]     sum;
  logic [2*W-1:0] acc_sh;
  logic [2*W-1:0] prod;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] x
  );
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  // State register; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (!cr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing IDLE -> RD -> MUL x32 -> WB
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RD;
      RD:   state_d = MUL;
      MUL:  if (cnt_q == CW'(W-1)) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One shift-add step: low half of acc holds the remaining multiplier
  always_comb begin
    sum    = {1'b0, acc_q[2*W-1:W]}
           + {1'b0, (acc_q[0] ? mcand_q : W'(0))};
    acc_sh = {sum, acc_q[W-1:1]};
    prod   = neg_q ? (~acc_sh + (2*W)'(1)) : acc_sh;
  end

  // Datapath next-state: capture, iterate, and stage the write-back
  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    dlo_d    = dlo_q;
    dhi_d    = dhi_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    aw1_d    = aw1_q;
    aw2_d    = aw2_q;
    di1_d    = di1_q;
    di2_d    = di2_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_a_d = src_a;
          addr_b_d = src_b;
          dlo_d    = dst_lo;
          dhi_d    = dst_hi;
          sgn_d    = signed_op;
          err_d    = (dst_lo == dst_hi);
        end
      end
      RD: begin
        if (sgn_q) begin
          mcand_d = mag(rf.QA);
          acc_d   = {W'(0), mag(rf.QB)};
          neg_d   = rf.QA[W-1] ^ rf.QB[W-1];
        end else begin
          mcand_d = rf.QA;
          acc_d   = {W'(0), rf.QB};
          neg_d   = 1'b0;
        end
        cnt_d = '0;
      end
      MUL: begin
        acc_d = acc_sh;
        cnt_d = cnt_q + CW'(1);
        // Last step: register the final product so it is
        // presented during WB and held afterwards
        if (cnt_q == CW'(W-1)) begin
          we_d  = 1'b1;
          aw1_d = dlo_q;
          di1_d = prod[W-1:0];
          // Same destination twice: write the low word only
          aw2_d = err_q ? dlo_q : dhi_q;
          di2_d = err_q ? prod[W-1:0] : prod[2*W-1:W];
        end
      end
      WB: begin
        we_d = 1'b0;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset clears every visible output
  always_ff @(posedge clk) begin
    if (!cr) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      dlo_q    <= '0;
      dhi_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      aw1_q    <= '0;
      aw2_q    <= '0;
      di1_q    <= '0;
      di2_q    <= '0;
    end else begin
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      dlo_q    <= dlo_d;
      dhi_q    <= dhi_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      aw1_q    <= aw1_d;
      aw2_q    <= aw2_d;
      di1_q    <= di1_d;
      di2_q    <= di2_d;
    end
  end

  assign rf.Addr_A  = addr_a_q;
  assign rf.Addr_B  = addr_b_q;
  assign rf.WE      = we_q;
  assign rf.Addr_W1 = aw1_q;
  assign rf.Addr_W2 = aw2_q;
  assign rf.Di1     = di1_q;
  assign rf.Di2     = di2_q;

  assign busy    = (state_q != IDLE);
  assign done    = we_q;
  assign dst_err = err_q;

endmodule
